fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge port.
- Delivers one instruction per accepted fetch into the IF/ID stage.
- Honours the pipeline stall vector and applies branch/jump redirects, including a redirect that arrives while a memory access is outstanding.
- Sits between the pipeline control unit (stall vector, redirect) and the instruction bus / IF/ID register.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC value loaded by reset.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  6  pipeline stall vector. Bit 0 freezes fetch issue; bit 1 freezes IF/ID acceptance.
- br_flag  in  1  redirect request, valid for one cycle.
- br_target  in  ADDR_W  redirect address.
- mem_req  out  1  instruction-bus request.
- mem_addr  out  ADDR_W  request address.
- mem_ack  in  1  bus completion; may be high in the same cycle as mem_req.
- mem_rdata  in  32  instruction word, valid when mem_ack is high.
- if_valid  out  1  if_inst/if_pc hold a deliverable instruction.
- if_pc  out  ADDR_W  address of if_inst.
- if_inst  out  32  fetched instruction.
- stallreq_if  out  1  fetch is not ready; request to the control unit to freeze.

Behaviour:
- Reset (rst high at a clock edge):
  - pc=RESET_PC, state=IDLE.
  - mem_req=0, mem_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, stallreq_if=0.
  - Reset mid-transaction abandons the access; any later mem_ack is ignored while state is IDLE.
- States:
  - IDLE: one cycle after reset, then go to FETCH.
  - FETCH: issue or wait on a request for pc.
  - DROP: wait out a request that has been invalidated.
- Output slot: slot_free = !if_valid || !stall[1]. The downstream consumes the slot whenever if_valid && !stall[1].
- Issue: in FETCH, drive mem_req=1 and mem_addr=pc when slot_free && !stall[0].
- Bus rule: once mem_req is asserted, mem_req and mem_addr stay stable until mem_ack, even if stall or slot conditions change. Use an outstanding flag to enforce this.
- Acknowledge in FETCH, no redirect:
  - On that edge: if_inst<=mem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4.
  - PC wraps modulo 2^ADDR_W, so 0xFFFF_FFFC goes to 0.
  - With a zero-wait bus, throughput is one instruction per cycle.
- if_valid clears when the slot is consumed and no new acknowledge arrives in the same cycle.
- stallreq_if = (state==FETCH && outstanding-or-issuing && !mem_ack) || state==DROP.
- Redirect (br_flag=1) has priority over stall and over a same-cycle acknowledge:
  - pc<=br_target with bits [1:0] forced to 0; if_valid<=0.
  - If a request is outstanding and mem_ack=0: go to DROP, keeping mem_req and mem_addr at the old address.
  - Otherwise (no request outstanding, or acknowledge in the same cycle): discard any data and stay in FETCH at the new pc.
- DROP:
  - On mem_ack, discard the data and go to FETCH; the new request is issued the next cycle.
  - A further br_flag while in DROP overwrites pc and stays in DROP.
- stall[0] high with no request outstanding: no issue, pc holds.
- stall[1] high with if_valid=1: if_valid, if_pc and if_inst hold; no new issue.
- Latency: rst falls before edge N. IDLE during cycle N, mem_req=1 in cycle N+1. With a zero-wait acknowledge, if_valid=1 in cycle N+2.

Decomposition:
- Shared defines header holds:
  - ZeroWord, InstAddrBus, InstBus.
  - Stall bit indices STALL_IF=0, STALL_ID=1.
  - State encodings FS_IDLE/FS_FETCH/FS_DROP.
  - PC increment constant 4.
- Single module; the PC/next-PC logic may be split into the sub-module fetch_pc_next (combinational mux: hold, +4, or redirect target).

Test Plan:
- Zero-wait bus, reset released: mem_addr steps 0x0, 0x4, 0x8 on consecutive cycles; if_pc equals each address one cycle later; if_inst echoes mem_rdata.
- Bus with a 3-cycle acknowledge at pc=0x10: mem_req and mem_addr=0x10 are stable for 3 cycles; stallreq_if=1 for 2 cycles; if_valid=1 with if_pc=0x10 after the acknowledge.
- Redirect to 0x103 while the request for 0x20 is outstanding: controller stays in DROP until the acknowledge; 0x20 data is never presented; next mem_addr=0x100.
- Redirect in the same cycle as the acknowledge for 0x8: data dropped; if_valid=0; next mem_addr=br_target.
- stall[1] held for 4 cycles with if_valid=1 at pc 0x4: outputs stable, no mem_req; fetching resumes at 0x8 on release.
- PC 0xFFFF_FFFC acknowledged: next mem_addr=0x0. Assert rst mid-wait: all outputs return to reset values the next cycle, and a late mem_ack has no effect.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
//   - bus widths and the zero word
//   - stall vector bit positions
//   - fetch FSM state encodings and PC-source select
//   - PC increment step
package fetch_ctrl_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam logic [InstBus-1:0] ZeroWord = '0;

    localparam int unsigned STALL_W  = 6;
    localparam int unsigned STALL_IF = 0;
    localparam int unsigned STALL_ID = 1;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_DROP  = 2'd2
    } fs_state_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_STEP  = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC mux: hold, sequential step, or word-aligned redirect target.
// Ports:
//   sel        - source select
//   pc         - current program counter
//   target     - redirect address (low two bits ignored)
//   pc_next_c  - combinational next PC
module fetch_pc_next
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBus
) (
    input  pc_sel_e            sel,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  target,
    output logic [ADDR_W-1:0]  pc_next_c
);

    // Step wraps naturally modulo 2^ADDR_W.
    always_comb begin
        pc_next_c = pc;
        case (sel)
            PC_STEP:  pc_next_c = pc + ADDR_W'(PC_INC);
            PC_REDIR: pc_next_c = target & ~ADDR_W'(3);
            default:  pc_next_c = pc;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction bus and
// fills the IF/ID slot one instruction per accepted fetch.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   stall[5:0]          - bit 0 freezes issue, bit 1 freezes IF/ID acceptance
//   br_flag, br_target  - one-cycle redirect request and address
//   mem_req, mem_addr   - bus request (held stable until mem_ack)
//   mem_ack, mem_rdata  - bus completion and instruction word
//   if_valid/if_pc/if_inst - IF/ID slot contents
//   stallreq_if         - fetch not ready, freeze request to control unit
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = InstAddrBus,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               br_flag,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [InstBus-1:0] mem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [InstBus-1:0] if_inst,
    output logic               stallreq_if
);

    fs_state_e          state_q, state_nxt;
    logic [ADDR_W-1:0]  pc_q, pc_nxt;
    logic               outstanding_q, outstanding_nxt;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_nxt;
    logic               if_valid_nxt;
    logic [ADDR_W-1:0]  if_pc_nxt;
    logic [InstBus-1:0] if_inst_nxt;
    pc_sel_e            pc_sel;
    logic               slot_free;
    logic               issue;
    logic               unused_stall_c;

    assign unused_stall_c = ^stall[STALL_W-1:2];

    fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .sel       (pc_sel),
        .pc        (pc_q),
        .target    (br_target),
        .pc_next_c (pc_nxt)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_IDLE;
            pc_q          <= RESET_PC;
            outstanding_q <= 1'b0;
            req_addr_q    <= RESET_PC;
            if_valid      <= 1'b0;
            if_pc         <= '0;
            if_inst       <= ZeroWord;
        end else begin
            state_q       <= state_nxt;
            pc_q          <= pc_nxt;
            outstanding_q <= outstanding_nxt;
            req_addr_q    <= req_addr_nxt;
            if_valid      <= if_valid_nxt;
            if_pc         <= if_pc_nxt;
            if_inst       <= if_inst_nxt;
        end
    end

    // Next-state, bus drive and slot update.
    always_comb begin
        state_nxt       = state_q;
        outstanding_nxt = outstanding_q;
        req_addr_nxt    = req_addr_q;
        if_valid_nxt    = if_valid;
        if_pc_nxt       = if_pc;
        if_inst_nxt     = if_inst;
        pc_sel          = PC_HOLD;
        issue           = 1'b0;
        mem_req         = 1'b0;
        stallreq_if     = 1'b0;
        slot_free       = !if_valid || !stall[STALL_ID];
        // A held request keeps its latched address; otherwise present the PC.
        mem_addr        = outstanding_q ? req_addr_q : pc_q;

        // Slot consumed downstream; a capture below overrides this.
        if (if_valid && !stall[STALL_ID]) begin
            if_valid_nxt = 1'b0;
        end

        case (state_q)
            FS_IDLE: begin
                state_nxt = FS_FETCH;
            end
            FS_FETCH: begin
                issue       = !outstanding_q && slot_free && !stall[STALL_IF];
                mem_req     = outstanding_q || issue;
                stallreq_if = mem_req && !mem_ack;
                if (br_flag) begin
                    pc_sel       = PC_REDIR;
                    if_valid_nxt = 1'b0;
                    if (mem_req && !mem_ack) begin
                        // Request already on the bus: wait it out in DROP.
                        state_nxt       = FS_DROP;
                        outstanding_nxt = 1'b1;
                        req_addr_nxt    = mem_addr;
                    end else begin
                        outstanding_nxt = 1'b0;
                    end
                end else if (mem_req && mem_ack) begin
                    pc_sel          = PC_STEP;
                    outstanding_nxt = 1'b0;
                    if_valid_nxt    = 1'b1;
                    if_pc_nxt       = pc_q;
                    if_inst_nxt     = mem_rdata;
                end else if (mem_req) begin
                    outstanding_nxt = 1'b1;
                    req_addr_nxt    = mem_addr;
                end
            end
            FS_DROP: begin
                mem_req     = 1'b1;
                stallreq_if = 1'b1;
                if (br_flag) begin
                    pc_sel = PC_REDIR;
                end
                if (mem_ack) begin
                    state_nxt       = FS_FETCH;
                    outstanding_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt       = FS_IDLE;
                outstanding_nxt = 1'b0;
            end
        endcase
    end

endmodule
